mmu_seq_ctrl: RTL and testbench
===============================

// Module: mmu_seq_ctrl
// PURPOSE
//   Sequencer for the SIZE x SIZE weight-stationary systolic array (mmu). Loads one weight tile through the array's
//   weight-shift path, then streams num_rows input vectors with per-lane skew. It tags every issue slot, and
//   deskews/captures the accumulator outputs into aligned result vectors. It sits between the tile buffers and the mmu.
// PARAMETERS
//   SIZE       4   array dimension (lanes, weight rows)
//   BIT_WIDTH  8   data/weight element width
//   ACC_WIDTH  32  accumulator element width
//   MAX_ROWS   16  max input vectors per job
//   OUT_LAT    8   cycles from lane-0 data on mmu_data_arr to lane-0 result on mmu_acc_out
// PORTS
//   clk           in   1                      clock, rising edge
//   rst_n         in   1                      asynchronous active-low reset
//   start         in   1                      job start pulse (sampled in IDLE only)
//   num_rows      in   $clog2(MAX_ROWS+1)     vectors in job, sampled with start
//   busy          out  1                      high from start accept until done
//   done          out  1                      one-cycle pulse, job complete
//   w_valid/w_ready  in/out  1               weight row handshake
//   w_data        in   SIZE*BIT_WIDTH         weight row, lane 0 in MSBs
//   d_valid/d_ready  in/out  1               input vector handshake
//   d_data        in   SIZE*BIT_WIDTH         input vector, lane 0 in MSBs
//   mmu_control   out  1                      1 = shift weights, 0 = compute
//   mmu_wt_arr    out  SIZE*BIT_WIDTH         weight row to array
//   mmu_data_arr  out  SIZE*BIT_WIDTH         skewed data to array
//   mmu_acc_out   in   SIZE*ACC_WIDTH         array outputs, lane 0 in MSBs
//   r_valid       out  1                      result vector valid (no backpressure)
//   r_data        out  SIZE*ACC_WIDTH         deskewed result vector
//   r_last        out  1                      with r_valid on final result of job
// BEHAVIOUR
//   Reset: FSM=IDLE, all outputs 0, skew/deskew/tag pipelines and counters cleared; applies mid-job, job abandoned.
//   FSM: IDLE -start-> LOAD_W -SIZE beats-> STREAM -num_rows accepted-> DRAIN -tags empty-> DONE -> IDLE.
//     num_rows==0: LOAD_W -> DONE directly (weights loaded, no results). num_rows>MAX_ROWS clamps to MAX_ROWS.
//     start while busy ignored. busy=1 in LOAD_W/STREAM/DRAIN/DONE; done=1 only in DONE cycle.
//   LOAD_W: w_ready=1. Beat accepted at cycle t -> mmu_wt_arr=w_data and mmu_control=1 at t+1.
//     No beat -> mmu_control=0, mmu_wt_arr holds. Rows sent last row first (row SIZE-1 first, row 0 last).
//     After SIZE beats w_ready drops same cycle as the last accept.
//   STREAM: d_ready=1 while rows_issued<num_rows. Each cycle is an issue slot: accepted vector, or bubble (zeros).
//     Skew: lane i of the slot issued at t appears on mmu_data_arr at t+1+i; lane 0 has 1 register, lane i has 1+i.
//     Tag bit (1 = real row) enters a shift pipe of depth OUT_LAT+SIZE; bubbles carry tag 0.
//   DRAIN: d_ready=0, zeros issued, mmu_control=0; wait until tag pipe has no 1s, then DONE.
//   Capture: result lane k sampled from mmu_acc_out at t+1+OUT_LAT+k; lane k then delayed SIZE-1-k cycles.
//     Result is aligned, r_data/r_valid registered at t+1+OUT_LAT+SIZE (tag=1 slots only).
//   Ordering: results in input order, one per accepted vector, exactly num_rows per job; r_last on the num_rows-th.
//   mmu_control never 1 outside LOAD_W. ACC values passed unmodified (no saturation/truncation).
//   New start accepted the cycle after DONE; back-to-back jobs reload weights.
// TESTING
//   Weights all 1, num_rows=1, d_data={1,2,3,4} -> one r_valid, every r_data lane=10, r_last=1, done next cycle.
//   Identity weights, 4 rows d=0x01020304..0x0D0E0F10, d_valid always 1 -> r_data matches golden per row, 4 beats.
//   Same job, d_valid toggled 1-0-0-1 -> bubbles; results unchanged, r_valid gaps match input gaps.
//   w_valid gaps during LOAD_W -> mmu_control low in gap cycles; exactly 4 control=1 cycles; results correct.
//   num_rows=0 -> 4 weight beats, no r_valid, done pulse; start asserted mid-job ignored.
//   rst_n low during STREAM row 2 -> all outputs 0 immediately; following job produces correct results.

Source files
------------

// File: rtl/mmu_seq_ctrl.sv
// Sequencer for the SIZE x SIZE weight-stationary systolic array: loads a weight tile, streams
// per-lane skewed input vectors, and deskews the accumulator outputs into aligned result vectors.
module mmu_seq_ctrl #(
  parameter int SIZE       = 4,
  parameter int BIT_WIDTH  = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int MAX_ROWS   = 16,
  parameter int OUT_LAT    = 8,
  localparam int CNT_W     = $clog2(MAX_ROWS + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [CNT_W-1:0]               num_rows,
  output logic                           busy,
  output logic                           done,
  input  logic                           w_valid,
  output logic                           w_ready,
  input  logic [SIZE*BIT_WIDTH-1:0]      w_data,
  input  logic                           d_valid,
  output logic                           d_ready,
  input  logic [SIZE*BIT_WIDTH-1:0]      d_data,
  output logic                           mmu_control,
  output logic [SIZE*BIT_WIDTH-1:0]      mmu_wt_arr,
  output logic [SIZE*BIT_WIDTH-1:0]      mmu_data_arr,
  input  logic [SIZE*ACC_WIDTH-1:0]      mmu_acc_out,
  output logic                           r_valid,
  output logic [SIZE*ACC_WIDTH-1:0]      r_data,
  output logic                           r_last
);

  localparam int DW    = SIZE * BIT_WIDTH;
  localparam int AW    = SIZE * ACC_WIDTH;
  localparam int TAG_D = OUT_LAT + SIZE;
  localparam int WC_W  = $clog2(SIZE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_rows_q, num_rows_d;
  logic [CNT_W-1:0] rows_issued_q, rows_issued_d;
  logic [WC_W-1:0]  w_cnt_q, w_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             w_ready_q, w_ready_d;
  logic             d_ready_q, d_ready_d;
  logic             mmu_control_q, mmu_control_d;
  logic [DW-1:0]    mmu_wt_arr_q, mmu_wt_arr_d;
  logic [TAG_D-1:0] tag_q, tag_d;
  logic [TAG_D-1:0] last_q, last_d;
  logic             r_valid_q, r_valid_d;
  logic             r_last_q, r_last_d;
  logic [AW-1:0]    r_data_q, r_data_d;

  logic             w_fire, d_fire, slot_last;
  logic [CNT_W-1:0] num_rows_clamped;
  logic [DW-1:0]    slot_data;
  logic [AW-1:0]    aligned;

  // NOTE: every variable written here gets a default first, so no path can leave a latch behind.
  always_comb begin
    w_fire           = w_valid && w_ready_q;
    d_fire           = d_valid && d_ready_q;
    num_rows_clamped = (num_rows > CNT_W'(MAX_ROWS)) ? CNT_W'(MAX_ROWS) : num_rows;

    state_d       = state_q;
    num_rows_d    = num_rows_q;
    rows_issued_d = rows_issued_q;
    w_cnt_d       = w_cnt_q;
    mmu_control_d = w_fire;
    mmu_wt_arr_d  = w_fire ? w_data : mmu_wt_arr_q;
    slot_data     = d_fire ? d_data : '0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          num_rows_d    = num_rows_clamped;
          rows_issued_d = '0;
          w_cnt_d       = '0;
          state_d       = S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (w_fire) begin
          w_cnt_d = w_cnt_q + WC_W'(1);
          if (w_cnt_q == WC_W'(SIZE - 1)) begin
            state_d = (num_rows_q == '0) ? S_DONE : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (d_fire) begin
          rows_issued_d = rows_issued_q + CNT_W'(1);
          if (rows_issued_d == num_rows_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Zeros keep flowing into the array until the last real row has left the tag pipe.
        if (tag_q == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    slot_last = d_fire && (rows_issued_d == num_rows_q);

    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
    w_ready_d = (state_d == S_LOAD_W);
    d_ready_d = (state_d == S_STREAM);

    tag_d     = {tag_q[TAG_D-2:0], d_fire};
    last_d    = {last_q[TAG_D-2:0], slot_last};
    r_valid_d = tag_q[TAG_D-1];
    r_last_d  = last_q[TAG_D-1];
    r_data_d  = tag_q[TAG_D-1] ? aligned : '0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      num_rows_q    <= '0;
      rows_issued_q <= '0;
      w_cnt_q       <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      w_ready_q     <= 1'b0;
      d_ready_q     <= 1'b0;
      mmu_control_q <= 1'b0;
      mmu_wt_arr_q  <= '0;
      tag_q         <= '0;
      last_q        <= '0;
      r_valid_q     <= 1'b0;
      r_last_q      <= 1'b0;
      r_data_q      <= '0;
    end else begin
      state_q       <= state_d;
      num_rows_q    <= num_rows_d;
      rows_issued_q <= rows_issued_d;
      w_cnt_q       <= w_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      w_ready_q     <= w_ready_d;
      d_ready_q     <= d_ready_d;
      mmu_control_q <= mmu_control_d;
      mmu_wt_arr_q  <= mmu_wt_arr_d;
      tag_q         <= tag_d;
      last_q        <= last_d;
      r_valid_q     <= r_valid_d;
      r_last_q      <= r_last_d;
      r_data_q      <= r_data_d;
    end
  end

  // Input skew: lane i of an issue slot reaches the array i cycles after lane 0.
  for (genvar i = 0; i < SIZE; i++) begin : g_skew
    logic [i:0][BIT_WIDTH-1:0] skew_q, skew_d;

    always_comb begin
      skew_d[0] = slot_data[(SIZE-1-i)*BIT_WIDTH +: BIT_WIDTH];
      for (int j = 1; j <= i; j++) begin
        skew_d[j] = skew_q[j-1];
      end
    end

    // NOTE: the skew/deskew pipes are reset so an abandoned job leaves no stale data behind.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skew_q <= '0;
      end else begin
        skew_q <= skew_d;
      end
    end

    assign mmu_data_arr[(SIZE-1-i)*BIT_WIDTH +: BIT_WIDTH] = skew_q[i];
  end

  // Output deskew: lane k emerges k cycles late, so it waits SIZE-1-k cycles to line up.
  for (genvar k = 0; k < SIZE; k++) begin : g_deskew
    localparam int N = SIZE - 1 - k;
    logic [ACC_WIDTH-1:0] lane_acc;
    assign lane_acc = mmu_acc_out[(SIZE-1-k)*ACC_WIDTH +: ACC_WIDTH];

    if (N == 0) begin : g_direct
      assign aligned[(SIZE-1-k)*ACC_WIDTH +: ACC_WIDTH] = lane_acc;
    end else begin : g_pipe
      logic [N-1:0][ACC_WIDTH-1:0] dsk_q, dsk_d;

      always_comb begin
        dsk_d[0] = lane_acc;
        for (int j = 1; j < N; j++) begin
          dsk_d[j] = dsk_q[j-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dsk_q <= '0;
        end else begin
          dsk_q <= dsk_d;
        end
      end

      assign aligned[(SIZE-1-k)*ACC_WIDTH +: ACC_WIDTH] = dsk_q[N-1];
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_ready     = w_ready_q;
  assign d_ready     = d_ready_q;
  assign mmu_control = mmu_control_q;
  assign mmu_wt_arr  = mmu_wt_arr_q;
  assign r_valid     = r_valid_q;
  assign r_last      = r_last_q;
  assign r_data      = r_data_q;

endmodule

// File: tb/tb_mmu_seq_ctrl.sv
// Directed bench for mmu_seq_ctrl: a small behavioural array model closes the loop between the
// sequencer's skewed data and its accumulator input; results are compared with hand-derived rows.
module tb_mmu_seq_ctrl;

  localparam int SIZE     = 4;
  localparam int BW       = 8;
  localparam int AW       = 32;
  localparam int MAX_ROWS = 16;
  localparam int OUT_LAT  = 8;
  localparam int DW       = SIZE * BW;
  localparam int RW       = SIZE * AW;
  localparam int LAT      = OUT_LAT + SIZE + 1;
  localparam int CNT_W    = $clog2(MAX_ROWS + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_rows = '0;
  logic             busy, done;
  logic             w_valid = 1'b0;
  logic             w_ready;
  logic [DW-1:0]    w_data = '0;
  logic             d_valid = 1'b0;
  logic             d_ready;
  logic [DW-1:0]    d_data = '0;
  logic             mmu_control;
  logic [DW-1:0]    mmu_wt_arr, mmu_data_arr;
  logic [RW-1:0]    mmu_acc_out;
  logic             r_valid, r_last;
  logic [RW-1:0]    r_data;

  mmu_seq_ctrl #(
    .SIZE(SIZE), .BIT_WIDTH(BW), .ACC_WIDTH(AW), .MAX_ROWS(MAX_ROWS), .OUT_LAT(OUT_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_rows(num_rows), .busy(busy), .done(done),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
    .mmu_control(mmu_control), .mmu_wt_arr(mmu_wt_arr), .mmu_data_arr(mmu_data_arr),
    .mmu_acc_out(mmu_acc_out), .r_valid(r_valid), .r_data(r_data), .r_last(r_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: weights shift in at row 0 on each control cycle; output lane k in cycle c sums
  // lane i of the data seen at cycle c-OUT_LAT-k+i times weight[i][k].
  logic [BW-1:0] wt [SIZE][SIZE] = '{default: '0};
  logic [DW-1:0] hist [OUT_LAT+SIZE] = '{default: '0};

  always @(negedge clk) begin
    logic [AW-1:0] acc;
    if (mmu_control) begin
      for (int r = SIZE - 1; r > 0; r--)
        for (int l = 0; l < SIZE; l++) wt[r][l] = wt[r-1][l];
      for (int l = 0; l < SIZE; l++) wt[0][l] = mmu_wt_arr[(SIZE-1-l)*BW +: BW];
    end
    for (int h = OUT_LAT + SIZE - 1; h > 0; h--) hist[h] = hist[h-1];
    hist[0] = mmu_data_arr;
    for (int k = 0; k < SIZE; k++) begin
      acc = '0;
      for (int i = 0; i < SIZE; i++)
        acc += AW'(hist[OUT_LAT+k-i][(SIZE-1-i)*BW +: BW]) * AW'(wt[i][k]);
      mmu_acc_out[(SIZE-1-k)*AW +: AW] = acc;
    end
  end

  // Event monitor
  logic [RW-1:0] res_q[$];
  bit            rlast_q[$];
  int            rcyc_q[$], dacc_q[$], wacc_q[$], ctrl_q[$], done_q[$];
  bit            clr_req = 1'b0;

  always @(negedge clk) begin
    if (clr_req) begin
      res_q.delete(); rlast_q.delete(); rcyc_q.delete();
      dacc_q.delete(); wacc_q.delete(); ctrl_q.delete(); done_q.delete();
    end else begin
      if (r_valid) begin
        res_q.push_back(r_data); rlast_q.push_back(r_last); rcyc_q.push_back(cyc);
      end
      if (d_valid && d_ready) dacc_q.push_back(cyc);
      if (w_valid && w_ready) wacc_q.push_back(cyc);
      if (mmu_control) ctrl_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Row j carries lanes 4j+1 .. 4j+4 (lane 0 in the MSBs).
  function automatic logic [DW-1:0] row_data(input int j);
    logic [DW-1:0] v;
    for (int l = 0; l < SIZE; l++) v[(SIZE-1-l)*BW +: BW] = BW'(4 * j + l + 1);
    return v;
  endfunction

  // Identity weights return the row unchanged; all-ones weights give 16j+10 in every lane.
  function automatic logic [RW-1:0] exp_row(input bit ones, input int j);
    logic [RW-1:0] v;
    for (int l = 0; l < SIZE; l++)
      v[(SIZE-1-l)*AW +: AW] = ones ? AW'(16 * j + 10) : AW'(4 * j + l + 1);
    return v;
  endfunction

  task automatic clear_mon();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
  endtask

  task automatic do_job(input int n_req, input bit ones, input logic [3:0] wgap,
                        input logic [7:0] vpat, input bit poke, input int abort_at,
                        output int accepted);
    logic [DW-1:0] wrow [SIZE];
    int  guard;
    bit  seen;
    for (int b = 0; b < SIZE; b++) wrow[b] = ones ? 32'h0101_0101 : (32'h1 << (8 * b));
    clear_mon();
    start = 1'b1; num_rows = CNT_W'(n_req);
    tick();
    start = 1'b0;
    check("busy_on_start", busy, 1);
    for (int b = 0; b < SIZE; b++) begin
      if (wgap[b]) begin w_valid = 1'b0; tick(); end
      w_valid = 1'b1; w_data = wrow[b]; start = poke && (b == 1);
      guard = 0;
      while (!w_ready && guard < 20) begin tick(); guard++; end
      check($sformatf("w_ready_beat%0d", b), w_ready, 1);
      tick();
      start = 1'b0;
    end
    w_valid = 1'b0; w_data = '0;
    accepted = 0; seen = 1'b0;
    for (int p = 0; p < 300 && !seen; p++) begin
      if (done) begin
        seen = 1'b1;
      end else begin
        if (abort_at >= 0 && accepted == abort_at) begin
          #2 rst_n = 1'b0;
          #1;
          check("rst_ctrl_outs", {busy, done, w_ready, d_ready, mmu_control, r_valid, r_last,
                                  mmu_wt_arr, mmu_data_arr}, 0);
          check("rst_r_data", r_data, 0);
          d_valid = 1'b0; d_data = '0;
          return;
        end
        d_valid = vpat[p % 8];
        d_data  = d_valid ? row_data(accepted) : '0;
        if (d_valid && d_ready) accepted++;
        tick();
      end
    end
    check("done_seen", seen, 1);
    check("busy_at_done", busy, 1);
    d_valid = 1'b0; d_data = '0;
    tick();
    check("done_one_cycle", done, 0);
  endtask

  task automatic check_results(input int n, input bit ones);
    check("n_results", res_q.size(), n);
    for (int j = 0; j < n && j < res_q.size(); j++) begin
      check($sformatf("row%0d_data", j), res_q[j], exp_row(ones, j));
      check($sformatf("row%0d_last", j), rlast_q[j], (j == n - 1));
      if (j < dacc_q.size())
        check($sformatf("row%0d_latency", j), rcyc_q[j] - dacc_q[j], LAT);
    end
  endtask

  int acc;
  int gaps[4] = '{0, 3, 4, 7};

  initial begin
    repeat (3) tick();
    check("reset_ctrl_outs", {busy, done, w_ready, d_ready, mmu_control, r_valid, r_last,
                              mmu_wt_arr, mmu_data_arr}, 0);
    check("reset_r_data", r_data, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    // All-ones weights, single row {1,2,3,4}
    do_job(1, 1'b1, 4'b0000, 8'hFF, 1'b0, -1, acc);
    check("t1_accepted", acc, 1);
    check_results(1, 1'b1);
    check("t1_ctrl_beats", ctrl_q.size(), 4);
    if (done_q.size() > 0 && rcyc_q.size() > 0)
      check("t1_done_after_rvalid", done_q[0] - rcyc_q[0], 1);

    // Identity weights, 4 back-to-back rows
    do_job(4, 1'b0, 4'b0000, 8'hFF, 1'b0, -1, acc);
    check("t2_accepted", acc, 4);
    check_results(4, 1'b0);

    // Same job with d_valid pattern 1-0-0-1
    do_job(4, 1'b0, 4'b0000, 8'h99, 1'b0, -1, acc);
    check("t3_accepted", acc, 4);
    check_results(4, 1'b0);
    for (int j = 1; j < 4 && j < dacc_q.size(); j++)
      check($sformatf("t3_input_gap%0d", j), dacc_q[j] - dacc_q[0], gaps[j]);

    // Gaps on the weight stream
    do_job(2, 1'b0, 4'b0101, 8'hFF, 1'b0, -1, acc);
    check("t4_ctrl_beats", ctrl_q.size(), 4);
    for (int b = 0; b < 4 && b < ctrl_q.size() && b < wacc_q.size(); b++)
      check($sformatf("t4_ctrl_cycle%0d", b), ctrl_q[b], wacc_q[b] + 1);
    check_results(2, 1'b0);

    // Zero rows, with a start pulse while busy
    do_job(0, 1'b0, 4'b0000, 8'hFF, 1'b1, -1, acc);
    check("t5_accepted", acc, 0);
    check("t5_ctrl_beats", ctrl_q.size(), 4);
    check("t5_no_results", res_q.size(), 0);
    repeat (3) tick();
    check("t5_idle_busy", busy, 0);
    check("t5_idle_w_ready", w_ready, 0);

    // Reset while the third row is on offer, then a clean job
    do_job(4, 1'b0, 4'b0000, 8'hFF, 1'b0, 2, acc);
    tick();
    rst_n = 1'b1;
    tick();
    do_job(4, 1'b0, 4'b0000, 8'hFF, 1'b0, -1, acc);
    check("t6_accepted", acc, 4);
    check_results(4, 1'b0);

    // Oversized request clamps to MAX_ROWS
    do_job(20, 1'b0, 4'b0000, 8'hFF, 1'b0, -1, acc);
    check("t7_accepted", acc, MAX_ROWS);
    check_results(MAX_ROWS, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
